// File: rtl/mem_fill_pkg.sv
// Shared constants and the fill-FSM state type for the line-fill controller.
package mem_fill_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned ADDR_SIZE_DEF      = 15;
    localparam int unsigned WORDS_PER_LINE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/mem_fill_if.sv
// Request / memory / line bundle of the line-fill controller.
// Optional crit_valid/crit_data exist only with MEM_FILL_CRIT_WORD_FIRST_EN.
interface mem_fill_if
    import mem_fill_pkg::*;
#(
    parameter int unsigned ADDR_SIZE      = ADDR_SIZE_DEF,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
);

    logic                             req_valid;
    logic                             req_ready;
    logic [ADDR_SIZE-1:0]             req_addr;
    logic [ADDR_SIZE-1:0]             mem_addr;
    logic [DATA_W-1:0]                mem_rdata;
    logic                             line_valid;
    logic                             line_ready;
    logic [ADDR_SIZE-1:0]             line_addr;
    logic [DATA_W*WORDS_PER_LINE-1:0] line_data;
    logic                             busy;
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
    logic                             crit_valid;
    logic [DATA_W-1:0]                crit_data;
`endif

`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
    modport master (
        output req_valid, req_addr, mem_rdata, line_ready,
        input  req_ready, mem_addr, line_valid, line_addr, line_data, busy,
               crit_valid, crit_data
    );
    modport slave (
        input  req_valid, req_addr, mem_rdata, line_ready,
        output req_ready, mem_addr, line_valid, line_addr, line_data, busy,
               crit_valid, crit_data
    );
`else
    modport master (
        output req_valid, req_addr, mem_rdata, line_ready,
        input  req_ready, mem_addr, line_valid, line_addr, line_data, busy
    );
    modport slave (
        input  req_valid, req_addr, mem_rdata, line_ready,
        output req_ready, mem_addr, line_valid, line_addr, line_data, busy
    );
`endif

endinterface

// File: rtl/mem_fill_linebuf.sv
// Line buffer: W x 32-bit registers, single indexed word write, synchronous
// clear, and a flat packed view with word k at bits [32k+31:32k].
module mem_fill_linebuf
    import mem_fill_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input  logic                                clk,
    input  logic                                clear,
    input  logic                                wr_en,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]                   wr_data,
    output logic [DATA_W*WORDS_PER_LINE-1:0]    line_data
);

    logic [DATA_W-1:0] words_q [WORDS_PER_LINE];
    logic [DATA_W-1:0] words_d [WORDS_PER_LINE];

    // Next buffer contents: hold, or overwrite the one addressed word.
    always_comb begin
        words_d = words_q;
        if (wr_en) begin
            words_d[wr_idx] = wr_data;
        end
    end

    // Buffer registers, cleared synchronously.
    always_ff @(posedge clk) begin
        if (clear) begin
            words_q <= '{default: '0};
        end else begin
            words_q <= words_d;
        end
    end

    // Flatten the array into the packed line output.
    always_comb begin
        line_data = '0;
        for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
            line_data[k*DATA_W +: DATA_W] = words_q[k];
        end
    end

endmodule

// File: rtl/mem_fill_ctrl.sv
// Cache line-fill controller: accepts a miss address, reads the W words of
// its line from main memory (one-cycle read latency) and presents the line.
// Optional MEM_FILL_CRIT_WORD_FIRST_EN: fetch starting at the requested word,
// wrapping within the line, and pulse crit_valid/crit_data with that word.
module mem_fill_ctrl
    import mem_fill_pkg::*;
#(
    parameter int unsigned ADDR_SIZE      = ADDR_SIZE_DEF,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
    input logic       clk,
    input logic       reset,
    mem_fill_if.slave bus
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned CNT_W = $clog2(WORDS_PER_LINE + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST    = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]     CNT_ADV_END = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_SIZE-1:0] LINE_MASK   = ~ADDR_SIZE'(WORDS_PER_LINE - 1);

    fill_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]     start_q;
    logic [OFF_W-1:0]     req_start;
    logic [OFF_W-1:0]     nxt_idx;
    logic [OFF_W-1:0]     cap_idx;
    logic                 wr_en;
    logic [OFF_W-1:0]     wr_idx;
    logic [DATA_W*WORDS_PER_LINE-1:0] line_data_w;

`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
    logic [OFF_W-1:0]     start_d;
    logic                 crit_valid_q, crit_valid_d;
    logic [DATA_W-1:0]    crit_data_q, crit_data_d;
`else
    // Natural order: the word sequence always starts at slot 0.
    assign start_q = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = FILL;
            FILL:    if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    if (bus.line_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-decoded handshake outputs.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.line_valid = (state_q == DONE);
    end

    // Fill datapath: address sequencing and capture slot selection.
    // Slot indices are OFF_W wide so the wrap stays inside the line and
    // never carries into the base bits.
    always_comb begin
        cnt_d      = cnt_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
        start_d    = start_q;
        req_start  = bus.req_addr[OFF_W-1:0];
`else
        req_start  = '0;
`endif
        nxt_idx    = start_q + cnt_q[OFF_W-1:0] + OFF_W'(1);
        cap_idx    = start_q + cnt_q[OFF_W-1:0] - OFF_W'(1);
        wr_en      = 1'b0;
        wr_idx     = cap_idx;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    base_d     = bus.req_addr & LINE_MASK;
                    cnt_d      = '0;
                    mem_addr_d = (bus.req_addr & LINE_MASK) | ADDR_SIZE'(req_start);
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
                    start_d    = req_start;
`endif
                end
            end
            FILL: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                if (cnt_q < CNT_ADV_END) begin
                    mem_addr_d = base_q | ADDR_SIZE'(nxt_idx);
                end
                // Read data lags its address by one cycle: cnt=c captures word order[c-1].
                if (cnt_q != '0) begin
                    wr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            base_q     <= '0;
            mem_addr_q <= '0;
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
            start_q    <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
            start_q    <= start_d;
`endif
        end
    end

`ifdef MEM_FILL_CRIT_WORD_FIRST_EN
    // Critical word arrives at cnt=1 and is presented for exactly one cycle.
    always_comb begin
        crit_valid_d = (state_q == FILL) && (cnt_q == CNT_W'(1));
        crit_data_d  = crit_valid_d ? bus.mem_rdata : crit_data_q;
    end

    // Critical-word output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

    assign bus.crit_valid = crit_valid_q;
    assign bus.crit_data  = crit_data_q;
`endif

    mem_fill_linebuf #(
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_linebuf (
        .clk       (clk),
        .clear     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (bus.mem_rdata),
        .line_data (line_data_w)
    );

    assign bus.mem_addr  = mem_addr_q;
    assign bus.line_addr = base_q;
    assign bus.line_data = line_data_w;

endmodule
